ccm_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the `ccm` memory block. It parses a byte-stream load protocol and writes 32-bit words into ICCM or DCCM through a dedicated write port. It holds the `rv32i_x` core in reset until a start command arrives. Word addresses are driven in the same word-addressed form the `ccm` ports expect: byte address bits [31:2], zero-extended.

---
 rtl/ccm_loader_if.sv | 26 ++
 rtl/ccm_loader.sv | 166 ++++++++++++++++
 tb/tb_ccm_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ccm_loader_if.sv
// Byte-stream input and ccm write port of the boot loader, grouped as one bundle.
// The slave modport is the loader side; the master modport drives the stream and observes the port.
interface ccm_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_wr_en;
   logic        mem_wr_sel;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        core_hold;
   logic        load_err;
   logic [15:0] words_written;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
             core_hold, load_err, words_written
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_wr_en, mem_wr_sel, mem_wr_addr, mem_wr_data,
             core_hold, load_err, words_written
   );
endinterface

// File: rtl/ccm_loader.sv
// Boot loader: parses a byte-stream load protocol into ICCM/DCCM word writes and holds the core in reset.
// Optional trailing XOR checksum per frame is enabled by defining CCM_LOADER_CSUM_EN.
//
// state  | meaning
// S_CMD  | waiting for a command byte
// S_ADDR | collecting 4-byte base address, LSB first
// S_LEN  | collecting 4-byte word count, LSB first
// S_DATA | collecting data bytes, one write per 4 bytes
// S_CSUM | expecting the frame XOR byte (checksum builds only)
// S_RUN  | core released, stream locked out until reset
module ccm_loader #(
   parameter logic [7:0] CMD_ICCM  = 8'hA5,
   parameter logic [7:0] CMD_DCCM  = 8'h5A,
   parameter logic [7:0] CMD_START = 8'h0F
) (
   input  logic         clk,
   input  logic         rst,
   ccm_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_CMD  = 3'd0,
      S_ADDR = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
`ifdef CCM_LOADER_CSUM_EN
      S_CSUM = 3'd5,
`endif
      S_RUN  = 3'd4
   } state_t;

`ifdef CCM_LOADER_CSUM_EN
   localparam state_t S_END = S_CSUM;
`else
   localparam state_t S_END = S_CMD;
`endif

   state_t      r_state;
   logic [1:0]  r_cnt;
   logic        r_sel;
   logic [29:0] r_ptr;
   logic [31:0] r_len;
   logic [31:0] r_shift;
   logic        r_in_ready;
   logic        r_wr_en;
   logic        r_wr_sel;
   logic [31:0] r_wr_addr;
   logic [31:0] r_wr_data;
   logic        r_core_hold;
   logic        r_load_err;
   logic [15:0] r_words;
`ifdef CCM_LOADER_CSUM_EN
   logic [7:0]  r_xor;
`endif

   logic        w_accept;
   logic        w_last_byte;
   logic [31:0] w_shift;

   assign w_accept    = bus.in_valid & r_in_ready;
   assign w_last_byte = (r_cnt == 2'd3);
   // Bytes enter at the top and move down, so after 4 bytes the first one sits in [7:0].
   assign w_shift     = {bus.in_data, r_shift[31:8]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_CMD;
         r_cnt       <= 2'd0;
         r_sel       <= 1'b0;
         r_ptr       <= 30'd0;
         r_len       <= 32'd0;
         r_shift     <= 32'd0;
         r_in_ready  <= 1'b1;
         r_wr_en     <= 1'b0;
         r_wr_sel    <= 1'b0;
         r_wr_addr   <= 32'd0;
         r_wr_data   <= 32'd0;
         r_core_hold <= 1'b1;
         r_load_err  <= 1'b0;
         r_words     <= 16'd0;
`ifdef CCM_LOADER_CSUM_EN
         r_xor       <= 8'd0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         if (w_accept) begin
`ifdef CCM_LOADER_CSUM_EN
            r_xor <= r_xor ^ bus.in_data;
`endif
            case (r_state)
               S_CMD: begin
                  r_cnt <= 2'd0;
`ifdef CCM_LOADER_CSUM_EN
                  r_xor <= bus.in_data;
`endif
                  if (bus.in_data == CMD_ICCM) begin
                     r_sel   <= 1'b0;
                     r_state <= S_ADDR;
                  end else if (bus.in_data == CMD_DCCM) begin
                     r_sel   <= 1'b1;
                     r_state <= S_ADDR;
                  end else if (bus.in_data == CMD_START) begin
                     r_state     <= S_RUN;
                     r_in_ready  <= 1'b0;
                     r_core_hold <= 1'b0;
                  end else begin
                     r_load_err <= 1'b1;
                  end
               end
               S_ADDR: begin
                  r_shift <= w_shift;
                  r_cnt   <= r_cnt + 2'd1;
                  if (w_last_byte) begin
                     r_ptr   <= w_shift[31:2];
                     r_state <= S_LEN;
                  end
               end
               S_LEN: begin
                  r_shift <= w_shift;
                  r_cnt   <= r_cnt + 2'd1;
                  if (w_last_byte) begin
                     r_len   <= w_shift;
                     r_state <= (w_shift == 32'd0) ? S_END : S_DATA;
                  end
               end
               S_DATA: begin
                  r_shift <= w_shift;
                  r_cnt   <= r_cnt + 2'd1;
                  if (w_last_byte) begin
                     r_wr_en   <= 1'b1;
                     r_wr_sel  <= r_sel;
                     r_wr_addr <= {2'b00, r_ptr};
                     r_wr_data <= w_shift;
                     r_ptr     <= r_ptr + 30'd1;
                     r_len     <= r_len - 32'd1;
                     if (r_words != 16'hFFFF)
                        r_words <= r_words + 16'd1;
                     if (r_len == 32'd1)
                        r_state <= S_END;
                  end
               end
`ifdef CCM_LOADER_CSUM_EN
               S_CSUM: begin
                  if (bus.in_data != r_xor)
                     r_load_err <= 1'b1;
                  r_state <= S_CMD;
               end
`endif
               S_RUN: begin
               end
               default: r_state <= S_CMD;
            endcase
         end
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.mem_wr_en     = r_wr_en;
   assign bus.mem_wr_sel    = r_wr_sel;
   assign bus.mem_wr_addr   = r_wr_addr;
   assign bus.mem_wr_data   = r_wr_data;
   assign bus.core_hold     = r_core_hold;
   assign bus.load_err      = r_load_err;
   assign bus.words_written = r_words;

endmodule

// File: tb/tb_ccm_loader.sv
// Self-checking bench for ccm_loader: table-driven frames, randomized frames against a
// frame-level write model, and hand sequences for timing, reset, error and start lockout.
module tb_ccm_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ccm_loader_if bus();

   ccm_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        sel;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] base;
      int          n;
      int          gap;
      logic        exp_err;
      int          exp_words;
   } vec_t;

   wr_t         exp_q[$];
   wr_t         got_q[$];
   logic [31:0] tx_words[0:15];
   logic [7:0]  tx_xor;
   int          exp_words;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Every write strobe seen on the port is recorded for comparison against the model.
   always @(negedge clk) begin
      if (bus.mem_wr_en)
         got_q.push_back('{sel: bus.mem_wr_sel, addr: bus.mem_wr_addr, data: bus.mem_wr_data});
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int gap;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) begin
         bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      tx_xor       = tx_xor ^ b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
   endtask

   task automatic end_frame(input logic [7:0] flip);
`ifdef CCM_LOADER_CSUM_EN
      logic [7:0] c;
      c = tx_xor ^ flip;
      send_byte(c, 0);
`else
      if (flip != 8'd0) tx_xor = tx_xor;
`endif
   endtask

   // Frame-level model: a load frame produces n writes at consecutive 30-bit word pointers.
   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] base, input int n,
                             input int gap_max, input logic [7:0] flip, input bit model);
      logic [29:0] p;
      tx_xor = 8'd0;
      send_byte(cmd, gap_max);
      send_word(base, gap_max);
      send_word(32'(n), gap_max);
      for (int i = 0; i < n; i++) begin
         send_word(tx_words[i], gap_max);
         if (model) begin
            p = base[31:2] + 30'(i);
            exp_q.push_back('{sel: (cmd == 8'h5A), addr: {2'b00, p}, data: tx_words[i]});
            if (exp_words < 65535) exp_words++;
         end
      end
      end_frame(flip);
   endtask

   task automatic check_writes(input string name);
      wr_t g, e;
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({name, "_sel"},  64'(g.sel),  64'(e.sel));
         chk({name, "_addr"}, 64'(g.addr), 64'(e.addr));
         chk({name, "_data"}, 64'(g.data), 64'(e.data));
      end
      got_q.delete();
      exp_q.delete();
      chk({name, "_words"}, 64'(bus.words_written), 64'(exp_words));
   endtask

   vec_t tbl[4];

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      tx_xor       = 8'd0;
      exp_words    = 0;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
      chk("rst_wr_en",     64'(bus.mem_wr_en), 64'd0);
      chk("rst_core_hold", 64'(bus.core_hold), 64'd1);
      chk("rst_load_err",  64'(bus.load_err), 64'd0);
      chk("rst_words",     64'(bus.words_written), 64'd0);
      chk("rst_addr",      64'(bus.mem_wr_addr), 64'd0);

      // ICCM load from the plan, with strobe timing checked byte by byte.
      tx_xor = 8'd0;
      send_byte(8'hA5, 0);
      send_word(32'h0000_0100, 0);
      send_word(32'd2, 0);
      send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      chk("iccm_no_early_wr", 64'(bus.mem_wr_en), 64'd0);
      send_byte(8'h00, 0);
      chk("iccm_wr_pulse", 64'(bus.mem_wr_en), 64'd1);
      chk("iccm_wr_addr0", 64'(bus.mem_wr_addr), 64'h40);
      chk("iccm_wr_data0", 64'(bus.mem_wr_data), 64'h13);
      chk("iccm_words_1",  64'(bus.words_written), 64'd1);
      send_word(32'h0010_0093, 0);
      chk("iccm_wr_addr1", 64'(bus.mem_wr_addr), 64'h41);
      end_frame(8'd0);
      exp_q.push_back('{sel: 1'b0, addr: 32'h40, data: 32'h0000_0013});
      exp_q.push_back('{sel: 1'b0, addr: 32'h41, data: 32'h0010_0093});
      exp_words = 2;
      check_writes("iccm");
      chk("iccm_core_hold", 64'(bus.core_hold), 64'd1);

      tbl[0] = '{cmd: 8'hA5, base: 32'h0000_1003, n: 3, gap: 0, exp_err: 1'b0, exp_words: 5};
      tbl[1] = '{cmd: 8'h5A, base: 32'h2000_0000, n: 1, gap: 2, exp_err: 1'b0, exp_words: 6};
      tbl[2] = '{cmd: 8'hA5, base: 32'h0000_0040, n: 0, gap: 0, exp_err: 1'b0, exp_words: 6};
      tbl[3] = '{cmd: 8'h5A, base: 32'hFFFF_FFF8, n: 4, gap: 1, exp_err: 1'b0, exp_words: 10};
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) tx_words[i] = $urandom;
         send_frame(tbl[t].cmd, tbl[t].base, tbl[t].n, tbl[t].gap, 8'd0, 1'b1);
         check_writes($sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d_err", t), 64'(bus.load_err), 64'(tbl[t].exp_err));
         chk($sformatf("tbl%0d_words_abs", t), 64'(bus.words_written), 64'(tbl[t].exp_words));
      end

      for (int r = 0; r < 10; r++) begin
         logic [7:0] c;
         c = ($urandom_range(1, 0) == 0) ? 8'hA5 : 8'h5A;
         for (int i = 0; i < 16; i++) tx_words[i] = $urandom;
         send_frame(c, $urandom, int'($urandom_range(6, 0)), int'($urandom_range(2, 0)), 8'd0, 1'b1);
         check_writes($sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d_err", r), 64'(bus.load_err), 64'd0);
      end

      // DCCM load across the top of the word address space.
      tx_words[0] = 32'hDEAD_BEEF;
      tx_words[1] = 32'h0123_4567;
      send_frame(8'h5A, 32'hFFFF_FFFC, 2, 0, 8'd0, 1'b0);
      exp_q.push_back('{sel: 1'b1, addr: 32'h3FFF_FFFF, data: 32'hDEAD_BEEF});
      exp_q.push_back('{sel: 1'b1, addr: 32'h0000_0000, data: 32'h0123_4567});
      exp_words += 2;
      check_writes("wrap");

      // Bad command byte, then an empty frame.
      chk("bad_err_before", 64'(bus.load_err), 64'd0);
      send_byte(8'h77, 0);
      chk("bad_err_after", 64'(bus.load_err), 64'd1);
      send_frame(8'hA5, 32'h0000_0010, 0, 0, 8'd0, 1'b1);
      check_writes("bad_follow");
      chk("bad_err_sticky", 64'(bus.load_err), 64'd1);

      // Reset arrives together with the 4th data byte; that write must not fire.
      tx_xor = 8'd0;
      send_byte(8'hA5, 0);
      send_word(32'h0000_0200, 0);
      send_word(32'd1, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h44;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      exp_words    = 0;
      chk("mrst_wr_en",     64'(bus.mem_wr_en), 64'd0);
      chk("mrst_in_ready",  64'(bus.in_ready), 64'd1);
      chk("mrst_sel",       64'(bus.mem_wr_sel), 64'd0);
      chk("mrst_addr",      64'(bus.mem_wr_addr), 64'd0);
      chk("mrst_data",      64'(bus.mem_wr_data), 64'd0);
      chk("mrst_core_hold", 64'(bus.core_hold), 64'd1);
      chk("mrst_load_err",  64'(bus.load_err), 64'd0);
      chk("mrst_words",     64'(bus.words_written), 64'd0);
      got_q.delete();
      tx_words[0] = 32'h4433_2211;
      send_frame(8'hA5, 32'h0000_0200, 1, 0, 8'd0, 1'b0);
      exp_q.push_back('{sel: 1'b0, addr: 32'h80, data: 32'h4433_2211});
      exp_words = 1;
      check_writes("resend");

`ifdef CCM_LOADER_CSUM_EN
      for (int i = 0; i < 16; i++) tx_words[i] = $urandom;
      send_frame(8'h5A, 32'h0000_4000, 2, 1, 8'd0, 1'b1);
      check_writes("csum_ok");
      chk("csum_ok_err", 64'(bus.load_err), 64'd0);
      send_frame(8'hA5, 32'h0000_8000, 2, 0, 8'h01, 1'b1);
      check_writes("csum_bad");
      chk("csum_bad_err", 64'(bus.load_err), 64'd1);
`endif

      // Start command releases the core and locks the stream out.
      chk("start_hold_before", 64'(bus.core_hold), 64'd1);
      send_byte(8'h0F, 0);
      chk("start_hold_after",  64'(bus.core_hold), 64'd0);
      chk("start_ready_after", 64'(bus.in_ready), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
      @(posedge clk);
      for (int i = 0; i < 24; i++) begin
         bus.in_data = 8'($urandom);
         @(posedge clk);
      end
      #1;
      bus.in_valid = 1'b0;
      check_writes("lockout");
      chk("lockout_ready", 64'(bus.in_ready), 64'd0);
      chk("lockout_hold",  64'(bus.core_hold), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
